// File: rtl/tdo_output_mux_pkg.sv
// Shared JTAG types for the TDO output stage: FSM state encoding,
// the instruction opcodes used to populate the DR opcode table,
// and a helper for sizing the DR select field.
package tdo_output_mux_pkg;

    // FSM state encoding kept as plain constants so it can be compared
    // against legacy logic vectors without casts.
    typedef logic [1:0] tdo_state_t;

    localparam tdo_state_t ST_IDLE     = 2'd0;
    localparam tdo_state_t ST_SHIFT_IR = 2'd1;
    localparam tdo_state_t ST_SHIFT_DR = 2'd2;

    localparam int JTAG_IR_WIDTH = 5;

    // Instruction opcodes already in use on this TAP.
    typedef enum logic [JTAG_IR_WIDTH-1:0] {
        IR_EXTEST         = 5'h00,
        IR_IDCODE         = 5'h01,
        IR_SAMPLE_PRELOAD = 5'h02,
        IR_USER1          = 5'h08,
        IR_USER2          = 5'h09,
        IR_DEBUG          = 5'h0A,
        IR_BYPASS         = 5'h1F
    } jtag_instr_e;

    // The bypass cell is always a single bit long.
    localparam int BYPASS_LEN = 1;

    // Bits needed to index NUM_DR data registers plus the bypass slot.
    function automatic int tdo_sel_width(input int num_dr);
        return (num_dr < 1) ? 1 : $clog2(num_dr + 1);
    endfunction

endpackage

// File: rtl/tdo_output_mux_if.sv
// Bundle of TAP-side control/data signals and the TDO stage results.
// master = TAP controller / IR decode side, slave = the TDO output stage.
interface tdo_output_mux_if #(
    parameter int NUM_DR    = 6,
    parameter int IR_WIDTH  = 5,
    parameter int CNT_WIDTH = 16
);
    logic                 tlr_reset;
    logic                 ir_shift;
    logic                 dr_shift;
    logic [IR_WIDTH-1:0]  instruction;
    logic [NUM_DR-1:0]    dr_out;
    logic                 bypass_out;
    logic                 instr_out;
    logic                 TDO;
    logic                 TDO_en;
    logic [CNT_WIDTH-1:0] shift_count;
    logic                 overshift;

    modport master (
        output tlr_reset,
        output ir_shift,
        output dr_shift,
        output instruction,
        output dr_out,
        output bypass_out,
        output instr_out,
        input  TDO,
        input  TDO_en,
        input  shift_count,
        input  overshift
    );

    modport slave (
        input  tlr_reset,
        input  ir_shift,
        input  dr_shift,
        input  instruction,
        input  dr_out,
        input  bypass_out,
        input  instr_out,
        output TDO,
        output TDO_en,
        output shift_count,
        output overshift
    );

endinterface

// File: rtl/tdo_output_mux_sel_decode.sv
// Combinational instruction -> {DR select, declared chain length} matcher.
// The lowest-index table entry that matches wins; no match selects the
// bypass cell with a length of one.
module tdo_sel_decode
    import tdo_output_mux_pkg::*;
#(
    parameter int NUM_DR    = 6,
    parameter int IR_WIDTH  = 5,
    parameter int CNT_WIDTH = 16,
    parameter int SEL_WIDTH = tdo_sel_width(NUM_DR),
    parameter logic [NUM_DR-1:0][IR_WIDTH-1:0]  DR_OPCODES = '0,
    parameter logic [NUM_DR-1:0][CNT_WIDTH-1:0] DR_LENGTHS = '0
) (
    input  logic [IR_WIDTH-1:0]  instruction,
    output logic [SEL_WIDTH-1:0] sel,
    output logic [CNT_WIDTH-1:0] len
);

    logic [NUM_DR-1:0] hit;

    // One comparator per table entry.
    generate
        for (genvar gi = 0; gi < NUM_DR; gi++) begin : g_match
            assign hit[gi] = (DR_OPCODES[gi] == instruction);
        end
    endgenerate

    // Priority pick: scan from the top down so the lowest matching index
    // is the last one written and therefore wins.
    always_comb begin
        sel = SEL_WIDTH'(NUM_DR);
        len = CNT_WIDTH'(BYPASS_LEN);
        for (int i = NUM_DR - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel = SEL_WIDTH'(i);
                len = DR_LENGTHS[i];
            end
        end
    end

endmodule

// File: rtl/tdo_output_mux.sv
// TDO output stage. Picks the serial source (data register, bypass or IR)
// for the current scan, registers TDO/TDO_en on the falling edge of TCK,
// counts bits shifted and flags scans longer than the declared DR length.
module tdo_output_mux
    import tdo_output_mux_pkg::*;
#(
    parameter int NUM_DR    = 6,
    parameter int IR_WIDTH  = 5,
    parameter int CNT_WIDTH = 16,
    parameter logic [NUM_DR-1:0][IR_WIDTH-1:0] DR_OPCODES = {
        IR_EXTEST, IR_DEBUG, IR_USER2, IR_USER1, IR_SAMPLE_PRELOAD, IR_IDCODE
    },
    parameter logic [NUM_DR-1:0][CNT_WIDTH-1:0] DR_LENGTHS = {
        16'd24, 16'd40, 16'd8, 16'd32, 16'd24, 16'd32
    }
) (
    input  logic          TCK,
    input  logic          TRST,
    tdo_output_mux_if.slave bus
);

    localparam int SEL_WIDTH = tdo_sel_width(NUM_DR);

    typedef logic [SEL_WIDTH-1:0] tdo_sel_t;
    localparam tdo_sel_t SEL_BYPASS = tdo_sel_t'(NUM_DR);

    // Registered state
    tdo_state_t           state_reg, state_next;
    tdo_sel_t             sel_reg, sel_next;
    logic [CNT_WIDTH-1:0] len_reg, len_next;
    logic                 tdo_reg, tdo_next;
    logic                 tdo_en_reg, tdo_en_next;
    logic [CNT_WIDTH-1:0] count_reg, count_next;
    logic                 overshift_reg, overshift_next;

    // Decode results and source muxing
    tdo_sel_t             dec_sel;
    logic [CNT_WIDTH-1:0] dec_len;
    logic [NUM_DR:0]      src_vec;
    logic                 entry_bit;
    logic                 shift_bit;
    logic [CNT_WIDTH-1:0] count_inc;
    logic                 enter_dr;
    logic                 enter_ir;
    logic                 stay_dr;
    logic                 stay_ir;

    tdo_sel_decode #(
        .NUM_DR     (NUM_DR),
        .IR_WIDTH   (IR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH),
        .DR_OPCODES (DR_OPCODES),
        .DR_LENGTHS (DR_LENGTHS)
    ) u_sel_decode (
        .instruction (bus.instruction),
        .sel         (dec_sel),
        .len         (dec_len)
    );

    // Bypass sits in the slot just above the last data register, so one
    // index covers every DR source.
    assign src_vec   = {bus.bypass_out, bus.dr_out};
    assign entry_bit = src_vec[dec_sel];
    assign shift_bit = src_vec[sel_reg];

    // Saturating increment: the counter parks at all-ones on very long scans.
    assign count_inc = (&count_reg) ? count_reg : count_reg + CNT_WIDTH'(1);

    // dr_shift has priority over ir_shift; a DR scan can start from IDLE or
    // directly out of an IR scan, but never restarts an ongoing DR scan.
    assign enter_dr = bus.dr_shift && (state_reg != ST_SHIFT_DR);
    assign enter_ir = bus.ir_shift && !bus.dr_shift && (state_reg == ST_IDLE);
    assign stay_dr  = bus.dr_shift && (state_reg == ST_SHIFT_DR);
    assign stay_ir  = bus.ir_shift && !bus.dr_shift && (state_reg == ST_SHIFT_IR);

    // Next-state, output and counter logic for the three-state scan FSM.
    always_comb begin
        state_next     = ST_IDLE;
        sel_next       = sel_reg;
        len_next       = len_reg;
        tdo_next       = 1'b0;
        tdo_en_next    = 1'b0;
        count_next     = count_reg;
        overshift_next = overshift_reg;

        if (enter_dr) begin
            // Freeze the selection for the whole scan.
            state_next     = ST_SHIFT_DR;
            sel_next       = dec_sel;
            len_next       = dec_len;
            tdo_next       = entry_bit;
            tdo_en_next    = 1'b1;
            count_next     = CNT_WIDTH'(1);
            overshift_next = (CNT_WIDTH'(1) > dec_len);
        end else if (enter_ir) begin
            state_next     = ST_SHIFT_IR;
            tdo_next       = bus.instr_out;
            tdo_en_next    = 1'b1;
            count_next     = CNT_WIDTH'(1);
            overshift_next = 1'b0;
        end else if (stay_dr) begin
            state_next     = ST_SHIFT_DR;
            tdo_next       = shift_bit;
            tdo_en_next    = 1'b1;
            count_next     = count_inc;
            overshift_next = overshift_reg | (count_inc > len_reg);
        end else if (stay_ir) begin
            // IR length is not policed, so overshift is left untouched.
            state_next     = ST_SHIFT_IR;
            tdo_next       = bus.instr_out;
            tdo_en_next    = 1'b1;
            count_next     = count_inc;
        end
        // Otherwise: fall back to IDLE with the pad released; the count and
        // overshift of the last scan stay visible until the next scan starts.
    end

    // Falling-edge state register with synchronous active-low reset;
    // Test-Logic-Reset has the same effect and aborts any scan.
    always_ff @(negedge TCK) begin
        if (!TRST || bus.tlr_reset) begin
            state_reg     <= ST_IDLE;
            sel_reg       <= SEL_BYPASS;
            len_reg       <= CNT_WIDTH'(BYPASS_LEN);
            tdo_reg       <= 1'b0;
            tdo_en_reg    <= 1'b0;
            count_reg     <= '0;
            overshift_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            len_reg       <= len_next;
            tdo_reg       <= tdo_next;
            tdo_en_reg    <= tdo_en_next;
            count_reg     <= count_next;
            overshift_reg <= overshift_next;
        end
    end

    assign bus.TDO         = tdo_reg;
    assign bus.TDO_en      = tdo_en_reg;
    assign bus.shift_count = count_reg;
    assign bus.overshift   = overshift_reg;

endmodule

// File: tb/tb_tdo_output_mux.sv
// Self-checking bench for tdo_output_mux. Inputs change on the rising edge
// of TCK, the DUT updates on the falling edge, and a monitor compares the
// outputs against a queue of expected values just after each falling edge.
module tb_tdo_output_mux;

    localparam int NUM_DR    = 6;
    localparam int IR_WIDTH  = 5;
    localparam int CNT_WIDTH = 6;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    // Index 5 duplicates index 3's opcode with a different length so the
    // lowest-index priority is observable.
    localparam logic [NUM_DR-1:0][IR_WIDTH-1:0] TB_OPCODES = {
        5'h09, 5'h0A, 5'h09, 5'h08, 5'h02, 5'h01
    };
    localparam logic [NUM_DR-1:0][CNT_WIDTH-1:0] TB_LENGTHS = {
        6'd2, 6'd40, 6'd4, 6'd32, 6'd24, 6'd32
    };

    typedef struct {
        string tag;
        logic  tdo;
        logic  en;
        int    cnt;
        logic  ovs;
    } exp_t;

    logic TCK;
    logic TRST;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_txn    = 0;

    tdo_output_mux_if #(
        .NUM_DR    (NUM_DR),
        .IR_WIDTH  (IR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) bus ();

    tdo_output_mux #(
        .NUM_DR     (NUM_DR),
        .IR_WIDTH   (IR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .DR_OPCODES (TB_OPCODES),
        .DR_LENGTHS (TB_LENGTHS)
    ) dut (
        .TCK  (TCK),
        .TRST (TRST),
        .bus  (bus)
    );

    initial begin
        TCK = 1'b1;
        forever #5 TCK = ~TCK;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Queue one expectation, then let the falling edge and the next rising
    // edge pass so the caller can drive the following cycle's inputs.
    task automatic tick(input string tag, input logic etdo, input logic een,
                        input int ecnt, input logic eovs);
        exp_t x;
        x.tag = tag;
        x.tdo = etdo;
        x.en  = een;
        x.cnt = ecnt;
        x.ovs = eovs;
        sb_q.push_back(x);
        @(negedge TCK);
        @(posedge TCK);
    endtask

    // Drive the chosen DR with b and every other DR with ~b.
    task automatic set_dr(input int idx, input logic b);
        logic [NUM_DR-1:0] v;
        v = {NUM_DR{~b}};
        v[idx] = b;
        bus.dr_out = v;
    endtask

    task automatic set_sh(input logic irs, input logic drs);
        bus.ir_shift = irs;
        bus.dr_shift = drs;
    endtask

    // Monitor: pop one expectation per falling edge and compare.
    always @(negedge TCK) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_txn++;
            $display("txn %0d %s TDO=%b en=%b cnt=%0d ovs=%b", n_txn, mon_e.tag,
                     bus.TDO, bus.TDO_en, bus.shift_count, bus.overshift);
            check_val({mon_e.tag, "_tdo"}, 32'(bus.TDO), 32'(mon_e.tdo));
            check_val({mon_e.tag, "_en"},  32'(bus.TDO_en), 32'(mon_e.en));
            check_val({mon_e.tag, "_cnt"}, 32'(bus.shift_count), 32'(mon_e.cnt));
            check_val({mon_e.tag, "_ovs"}, 32'(bus.overshift), 32'(mon_e.ovs));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [31:0] pat;
        logic        b;
        logic [4:0]  ir_seq;
        logic [2:0]  byp_seq;
        int          c;

        TRST            = 1'b0;
        bus.tlr_reset   = 1'b0;
        bus.ir_shift    = 1'b0;
        bus.dr_shift    = 1'b0;
        bus.instruction = 5'h08;
        bus.dr_out      = '0;
        bus.bypass_out  = 1'b0;
        bus.instr_out   = 1'b0;
        @(posedge TCK);

        // Reset held with dr_shift high, then released straight into a scan.
        set_sh(1'b0, 1'b1);
        tick("rst0", 1'b0, 1'b0, 0, 1'b0);
        tick("rst1", 1'b0, 1'b0, 0, 1'b0);
        TRST = 1'b1;
        set_dr(2, 1'b1);
        tick("rst_rel", 1'b1, 1'b1, 1, 1'b0);
        set_sh(1'b0, 1'b0);
        tick("rst_idle", 1'b0, 1'b0, 1, 1'b0);

        // 32-bit DR2 scan, then one extra bit to trip overshift.
        pat = 32'hA5A5_0F0F;
        bus.instruction = 5'h08;
        set_sh(1'b0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            set_dr(2, pat[i]);
            tick("dr2", pat[i], 1'b1, i + 1, 1'b0);
        end
        set_dr(2, 1'b1);
        tick("dr2_over", 1'b1, 1'b1, 33, 1'b1);
        set_sh(1'b0, 1'b0);
        tick("dr2_exit", 1'b0, 1'b0, 33, 1'b1);
        tick("dr2_idle", 1'b0, 1'b0, 33, 1'b1);

        // Unassigned opcode selects bypass (length 1).
        byp_seq = 3'b101;
        bus.instruction = 5'h1E;
        set_sh(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bus.bypass_out = byp_seq[2 - i];
            bus.dr_out     = {NUM_DR{~byp_seq[2 - i]}};
            tick("byp", byp_seq[2 - i], 1'b1, i + 1, (i >= 1));
        end
        set_sh(1'b0, 1'b0);
        tick("byp_exit", 1'b0, 1'b0, 3, 1'b1);

        // Instruction switches to DR1's opcode mid-scan; DR0 stays selected.
        pat = 32'h0000_002D;
        bus.instruction = 5'h01;
        set_sh(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) bus.instruction = 5'h02;
            set_dr(0, pat[i]);
            tick("frz", pat[i], 1'b1, i + 1, 1'b0);
        end
        set_sh(1'b0, 1'b0);
        tick("frz_exit", 1'b0, 1'b0, 6, 1'b0);

        // Duplicate opcode: index 3 (length 4) must win over index 5 (length 2).
        pat = 32'h0000_0016;
        bus.instruction = 5'h09;
        set_sh(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            set_dr(3, pat[i]);
            tick("prio", pat[i], 1'b1, i + 1, (i + 1 > 4));
        end
        set_sh(1'b0, 1'b0);
        tick("prio_exit", 1'b0, 1'b0, 5, 1'b1);

        // IR scan: overshift cleared on entry and never set.
        ir_seq = 5'b10001;
        set_sh(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.instr_out = ir_seq[4 - i];
            bus.dr_out    = {NUM_DR{~ir_seq[4 - i]}};
            tick("ir", ir_seq[4 - i], 1'b1, i + 1, 1'b0);
        end
        set_sh(1'b0, 1'b0);
        tick("ir_exit", 1'b0, 1'b0, 5, 1'b0);

        // Both shifts high from IDLE: DR wins; TLR pulse aborts mid-scan.
        bus.instruction = 5'h02;
        set_sh(1'b1, 1'b1);
        bus.instr_out = 1'b1;
        set_dr(1, 1'b0);
        tick("both0", 1'b0, 1'b1, 1, 1'b0);
        bus.instr_out = 1'b0;
        set_dr(1, 1'b1);
        tick("both1", 1'b1, 1'b1, 2, 1'b0);
        bus.tlr_reset = 1'b1;
        tick("tlr", 1'b0, 1'b0, 0, 1'b0);
        bus.tlr_reset = 1'b0;
        set_sh(1'b0, 1'b0);
        tick("tlr_idle", 1'b0, 1'b0, 0, 1'b0);

        // IR scan interrupted by dr_shift: re-enters as a fresh DR scan.
        set_sh(1'b1, 1'b0);
        bus.instr_out = 1'b1;
        tick("ir2dr_a", 1'b1, 1'b1, 1, 1'b0);
        bus.instr_out = 1'b0;
        tick("ir2dr_b", 1'b0, 1'b1, 2, 1'b0);
        bus.instruction = 5'h1E;
        set_sh(1'b1, 1'b1);
        bus.instr_out  = 1'b1;
        bus.bypass_out = 1'b0;
        bus.dr_out     = '1;
        tick("ir2dr_c", 1'b0, 1'b1, 1, 1'b0);
        bus.bypass_out = 1'b1;
        bus.dr_out     = '0;
        tick("ir2dr_d", 1'b1, 1'b1, 2, 1'b1);
        set_sh(1'b0, 1'b0);
        tick("ir2dr_exit", 1'b0, 1'b0, 2, 1'b1);

        // Long DR4 scan past the counter's all-ones value: count saturates.
        bus.instruction = 5'h0A;
        set_sh(1'b0, 1'b1);
        for (int i = 0; i < 66; i++) begin
            b = 1'($urandom_range(0, 1));
            set_dr(4, b);
            c = (i + 1 > CNT_MAX) ? CNT_MAX : i + 1;
            tick("sat", b, 1'b1, c, (c > 40));
        end
        set_sh(1'b0, 1'b0);
        tick("sat_exit", 1'b0, 1'b0, CNT_MAX, 1'b1);

        repeat (2) @(negedge TCK);
        #2;
        check_val("queue_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tdo_output_mux.md
Name: tdo_output_mux

Overview:
Parametrised TDO output stage for the TAP. It selects among NUM_DR data-register serial outputs, the instruction register, and a bypass cell, all driven from an opcode table. TDO and its enable are updated on the falling edge of TCK. The data-register selection is latched at shift entry, and bits shifted per scan are counted and checked against the declared chain length. It sits between the TAP controller/IR decode and the TDO pad.

Parameters:
NUM_DR, 6, number of selectable data registers (excluding bypass)
IR_WIDTH, 5, instruction width in bits
CNT_WIDTH, 16, width of the shift-bit counter
DR_OPCODES, {NUM_DR{IR_WIDTH'}} packed array, opcode selecting each DR; index 0 has highest match priority
DR_LENGTHS, {NUM_DR{CNT_WIDTH'}} packed array, declared bit length of each DR chain (bypass length fixed at 1)

Ports:
TCK  in  1  test clock; all state updates on negedge TCK
TRST  in  1  reset, active-low, synchronous to negedge TCK
tlr_reset  in  1  TAP in Test-Logic-Reset; same effect as TRST low
ir_shift  in  1  TAP in Shift-IR
dr_shift  in  1  TAP in Shift-DR
instruction  in  IR_WIDTH  current latched instruction
dr_out  in  NUM_DR  serial LSB outputs of each data register
bypass_out  in  1  bypass cell output
instr_out  in  1  IR shift-stage output
TDO  out  1  test data out
TDO_en  out  1  pad drive enable; 0 = inactive (tri-state at pad)
shift_count  out  CNT_WIDTH  bits shifted in the current or last scan
overshift  out  1  sticky: current or last scan exceeded the declared length

Behaviour:
- Reset: one clock; reset is synchronous and active-low. The clock port is TCK and the reset port is TRST. On a negedge TCK with TRST==0 or tlr_reset==1: TDO=0, TDO_en=0, state=IDLE, sel_q=BYPASS, shift_count=0, overshift=0.
- States (tdo_state_t): IDLE, SHIFT_IR, SHIFT_DR. Evaluated every negedge TCK.
- IDLE:
  - dr_shift=1 → SHIFT_DR. Latch sel_q=decode(instruction). TDO=selected source, TDO_en=1, shift_count=1, overshift=(1>len(sel)).
  - else ir_shift=1 → SHIFT_IR. TDO=instr_out, TDO_en=1, shift_count=1, overshift=0.
  - else: TDO=0, TDO_en=0; count and overshift hold.
- SHIFT_DR, dr_shift=1:
  - TDO=dr_out[sel_q], or bypass_out if sel_q=BYPASS.
  - shift_count increments and saturates at all-ones (no wrap).
  - overshift set when the new count > len(sel_q); sticky.
  - A change in instruction mid-scan is ignored, because sel_q is frozen.
- SHIFT_IR, ir_shift=1: TDO=instr_out; count increments/saturates; overshift is never set for IR.
- Either shift state with its shift input deasserted → IDLE, TDO=0, TDO_en=0. shift_count and overshift hold their last-scan values until the next scan entry.
- dr_shift and ir_shift both high: dr_shift wins, in both IDLE and the shift states. From SHIFT_IR, dr_shift=1 (regardless of ir_shift) → SHIFT_DR with entry actions.
- decode: lowest index i with DR_OPCODES[i]==instruction. No match → BYPASS, len=1 (unassigned opcodes select bypass).
- Latency: source bit → TDO one negedge; TDO_en asserts on the same negedge as the first bit.
- tlr_reset mid-scan aborts immediately to the reset values.

Decomposition:
- jtag_types_pkg additions: tdo_state_t enum; tdo_sel_t (width $clog2(NUM_DR+1)) with BYPASS = NUM_DR; existing instruction enum values used to build DR_OPCODES at instantiation.
- Sub-module tdo_sel_decode: combinational instruction→{sel, len} priority matcher over DR_OPCODES/DR_LENGTHS. The top holds the FSM, counter and output registers.

Test Plan:
- TRST=0 for 2 negedges during dr_shift=1 → TDO=0, TDO_en=0, shift_count=0, overshift=0; release TRST with dr_shift=1 → next negedge TDO_en=1, shift_count=1.
- instruction=DR_OPCODES[2], DR_LENGTHS[2]=32, dr_shift for 32 negedges driving dr_out[2]=0xA5A5_0F0F LSB-first → TDO reproduces pattern, shift_count=32, overshift=0; 33rd bit → overshift=1 and stays 1 after exit.
- Unassigned opcode 5'h1E, dr_shift 3 cycles, bypass_out=1,0,1 → TDO=1,0,1, overshift=1 from the 2nd bit.
- Instruction changed from DR0 to DR1 opcode mid-SHIFT_DR → TDO keeps following dr_out[0].
- ir_shift 5 cycles with instr_out=1,0,0,0,1 → TDO same sequence, shift_count=5, overshift=0; then both shifts low → TDO_en=0, TDO=0, count holds 5.
- ir_shift and dr_shift both high from IDLE → SHIFT_DR entered; tlr_reset pulse mid-scan → next negedge TDO_en=0, shift_count=0.
